// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the MEM-stage data access path:
// FSM states, funct3 size/sign encodings and the size-to-strobe table.
package riscv_mem_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } mau_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Indexed by funct3[1:0]: byte, half, word, double.
    localparam logic [7:0] SIZE_STRB [4] = '{8'h01, 8'h03, 8'h0f, 8'hff};

    function automatic logic [7:0] size_strb(input logic [1:0] size);
        return SIZE_STRB[size];
    endfunction

    function automatic logic size_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off[0] == 1'b0);
            2'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Extracts the addressed lane from a doubleword read and sign/zero-extends
// it according to the load funct3.
module load_formatter
    import riscv_mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (funct3)
            F3_B:    data = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   data = {56'd0, shifted[7:0]};
            F3_HU:   data = {48'd0, shifted[15:0]};
            F3_WU:   data = {32'd0, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: branch resolution, a two-state data-memory request
// handshake with byte-lane steering, and the registered MEM/WB boundary.
module mem_access_unit
    import riscv_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] adder_out,
    input  logic        zero,
    input  logic [63:0] alu_result,
    input  logic [63:0] write_data,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic        regwrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        pcsrc,
    output logic [63:0] branch_target,
    output logic        mem_exc,
    output logic [63:0] wb_read_data,
    output logic [63:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_memtoreg,
    output logic        wb_regwrite
);

    mau_state_e  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [2:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regwrite_q, regwrite_d;
    logic [63:0] alu_q, alu_d;
    logic        mem_exc_q, mem_exc_d;
    logic [63:0] wb_read_data_q, wb_read_data_d;
    logic [63:0] wb_alu_result_q, wb_alu_result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic        wb_regwrite_q, wb_regwrite_d;

    logic        access, f3_ok, acc_legal, acc_illegal;
    logic [1:0]  size;
    logic [2:0]  off;
    logic [63:0] load_data;

    assign pcsrc         = branch & zero;
    assign branch_target = adder_out;

    assign size   = funct3[1:0];
    assign off    = alu_result[2:0];
    assign access = memread | memwrite;

    always_comb begin
        f3_ok = 1'b0;
        if (memread && !memwrite)      f3_ok = (funct3 != 3'b111);
        else if (memwrite && !memread) f3_ok = (funct3[2] == 1'b0);
    end

    assign acc_legal   = access && f3_ok && size_aligned(size, off);
    assign acc_illegal = access && !acc_legal;

    load_formatter u_load_formatter (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        off_d      = off_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        alu_d      = alu_q;
        mem_exc_d  = 1'b0;
        stall      = 1'b0;
        // MEM/WB defaults to a bubble; only completed operations overwrite it.
        wb_read_data_d  = '0;
        wb_alu_result_d = '0;
        wb_rd_d         = '0;
        wb_memtoreg_d   = 1'b0;
        wb_regwrite_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc_legal) begin
                    state_d    = BUSY;
                    stall      = 1'b1;
                    addr_d     = {alu_result[63:3], 3'b000};
                    we_d       = memwrite;
                    wdata_d    = memwrite ? (write_data << {off, 3'b000}) : '0;
                    wstrb_d    = memwrite ? (size_strb(size) << off) : '0;
                    off_d      = off;
                    f3_d       = funct3;
                    rd_d       = rd;
                    memtoreg_d = memtoreg;
                    regwrite_d = regwrite & ~memwrite;
                    alu_d      = alu_result;
                end else if (acc_illegal) begin
                    mem_exc_d = 1'b1;
                end else begin
                    wb_alu_result_d = alu_result;
                    wb_rd_d         = rd;
                    wb_memtoreg_d   = memtoreg;
                    wb_regwrite_d   = regwrite;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d         = IDLE;
                    wb_read_data_d  = we_q ? '0 : load_data;
                    wb_alu_result_d = alu_q;
                    wb_rd_d         = rd_q;
                    wb_memtoreg_d   = memtoreg_q;
                    wb_regwrite_d   = regwrite_q;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            off_q           <= '0;
            f3_q            <= '0;
            rd_q            <= '0;
            memtoreg_q      <= 1'b0;
            regwrite_q      <= 1'b0;
            alu_q           <= '0;
            mem_exc_q       <= 1'b0;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= '0;
            wb_rd_q         <= '0;
            wb_memtoreg_q   <= 1'b0;
            wb_regwrite_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            off_q           <= off_d;
            f3_q            <= f3_d;
            rd_q            <= rd_d;
            memtoreg_q      <= memtoreg_d;
            regwrite_q      <= regwrite_d;
            alu_q           <= alu_d;
            mem_exc_q       <= mem_exc_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_rd_q         <= wb_rd_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_regwrite_q   <= wb_regwrite_d;
        end
    end

    assign dmem_req      = (state_q == BUSY);
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_wstrb    = wstrb_q;
    assign mem_exc       = mem_exc_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_memtoreg   = wb_memtoreg_q;
    assign wb_regwrite   = wb_regwrite_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected MEM/WB
// records (tagged with the edge they appear on) and memory requests.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] adder_out, alu_result, write_data, dmem_rdata;
    logic        zero, branch, memread, memwrite, memtoreg, regwrite, dmem_ack;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, stall, pcsrc, mem_exc, wb_memtoreg, wb_regwrite;
    logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
    logic [7:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .adder_out(adder_out), .zero(zero),
        .alu_result(alu_result), .write_data(write_data), .rd(rd), .funct3(funct3),
        .branch(branch), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .mem_exc(mem_exc), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        mtr;
        logic        rw;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_exp_t;

    wb_exp_t     wbq[$];
    req_exp_t    reqq[$];
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MEM/WB monitor: tagged cycles must match the record, all others are bubbles.
    always @(negedge clk) begin
        if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
            wb_exp_t e;
            e = wbq.pop_front();
            chk("wb_read_data", wb_read_data, e.rdata);
            chk("wb_alu_result", wb_alu_result, e.alu);
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
            chk("wb_memtoreg", {63'd0, wb_memtoreg}, {63'd0, e.mtr});
            chk("wb_regwrite", {63'd0, wb_regwrite}, {63'd0, e.rw});
        end else if (!reset) begin
            chk("wb_bubble", {62'd0, wb_regwrite, wb_memtoreg}, 64'd0);
        end
    end

    // Request monitor: fields compared every cycle the request is up; popped on ack.
    always @(negedge clk) begin
        if (dmem_req && reqq.size() > 0) begin
            chk("dmem_addr", dmem_addr, reqq[0].addr);
            chk("dmem_we", {63'd0, dmem_we}, {63'd0, reqq[0].we});
            if (reqq[0].we) begin
                chk("dmem_wdata", dmem_wdata, reqq[0].wdata);
                chk("dmem_wstrb", {56'd0, dmem_wstrb}, {56'd0, reqq[0].wstrb});
            end
            if (dmem_ack) void'(reqq.pop_front());
        end else if (dmem_req) begin
            chk("unexpected_req", {63'd0, dmem_req}, 64'd0);
        end
    end

    task automatic drive_nop();
        memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0; branch = 0; zero = 0;
        rd = '0; funct3 = '0; alu_result = '0; write_data = '0; adder_out = '0;
    endtask

    task automatic do_alu(input logic [63:0] alu, input logic [4:0] rdv);
        wbq.push_back('{cyc + 1, 64'd0, alu, rdv, 1'b0, 1'b1});
        alu_result = alu; rd = rdv; regwrite = 1;
        #1 chk("stall_alu", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        drive_nop();
    endtask

    task automatic do_mem(input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] rdat, input logic [4:0] rdv,
                          input logic mtr, input int unsigned d, input logic [63:0] exp_rd,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
        wbq.push_back('{cyc + 2 + d, exp_rd, addr, rdv, mtr, ld});
        reqq.push_back('{addr & ~64'h7, ~ld, exp_wdata, exp_wstrb});
        memread = ld; memwrite = ~ld; funct3 = f3; alu_result = addr; write_data = wd;
        rd = rdv; memtoreg = mtr; regwrite = 1;
        #1 chk("stall_accept", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        drive_nop();
        chk("req_up", {63'd0, dmem_req}, 64'd1);
        dmem_rdata = rdat;
        repeat (d) begin
            #1 chk("stall_wait", {63'd0, stall}, 64'd1);
            @(posedge clk); #1;
        end
        dmem_ack = 1;
        #1 chk("stall_ack", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("req_drop", {63'd0, dmem_req}, 64'd0);
    endtask

    task automatic do_illegal(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr);
        wbq.push_back('{cyc + 1, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0});
        memread = ld; memwrite = st; funct3 = f3; alu_result = addr;
        write_data = 64'h1234; rd = 5'd4; regwrite = 1; memtoreg = ld;
        #1 chk("stall_illegal", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        drive_nop();
        chk("illegal_no_req", {63'd0, dmem_req}, 64'd0);
        chk("mem_exc_pulse", {63'd0, mem_exc}, 64'd1);
        @(posedge clk); #1;
        chk("mem_exc_clear", {63'd0, mem_exc}, 64'd0);
        chk("illegal_no_req2", {63'd0, dmem_req}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_nop();
        dmem_ack = 0; dmem_rdata = '0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_we", {63'd0, dmem_we}, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_wstrb", {56'd0, dmem_wstrb}, 64'd0);
        chk("rst_exc", {63'd0, mem_exc}, 64'd0);
        chk("rst_wb", wb_read_data | wb_alu_result | {59'd0, wb_rd}, 64'd0);

        do_alu(64'h55, 5'd3);
        // LW, sign-extended upper word, one wait cycle
        do_mem(1, 3'b010, 64'h1004, 0, 64'h80000000_00000000, 5'd5, 1, 1,
               64'hFFFFFFFF_80000000, 0, 0);
        // SB to lane 3 with three wait cycles; regwrite forced off
        do_mem(0, 3'b000, 64'h2003, 64'hAB, 0, 5'd7, 0, 3, 0,
               64'h00000000_AB000000, 8'h08);
        do_illegal(1, 0, 3'b001, 64'h3001);

        branch = 1; zero = 1; adder_out = 64'h400;
        #1 chk("pcsrc_taken", {63'd0, pcsrc}, 64'd1);
        chk("branch_target", branch_target, 64'h400);
        zero = 0;
        #1 chk("pcsrc_not_taken", {63'd0, pcsrc}, 64'd0);
        drive_nop();
        @(posedge clk); #1;

        // Reset while BUSY aborts; a later ack must be ignored
        reqq.push_back('{64'h4000, 1'b0, 64'd0, 8'd0});
        memread = 1; funct3 = 3'b011; alu_result = 64'h4000; rd = 5'd9;
        regwrite = 1; memtoreg = 1;
        #1 chk("stall_rst_accept", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        drive_nop();
        chk("rst_busy_req", {63'd0, dmem_req}, 64'd1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        void'(reqq.pop_front());
        chk("rst_abort_req", {63'd0, dmem_req}, 64'd0);
        @(posedge clk); #1;
        dmem_ack = 1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("ack_after_abort_req", {63'd0, dmem_req}, 64'd0);
        chk("ack_after_abort_stall", {63'd0, stall}, 64'd0);

        do_mem(1, 3'b100, 64'h7, 0, 64'hF000_0000_0000_0000, 5'd10, 1, 0,
               64'h0000_0000_0000_00F0, 0, 0);
        do_mem(1, 3'b001, 64'h12, 0, 64'h0000_0000_8001_0000, 5'd11, 1, 0,
               64'hFFFF_FFFF_FFFF_8001, 0, 0);
        do_mem(0, 3'b010, 64'h6004, 64'h11223344, 0, 5'd12, 0, 2, 0,
               64'h11223344_00000000, 8'hF0);
        do_mem(1, 3'b011, 64'h5008, 0, 64'h01234567_89ABCDEF, 5'd13, 1, 0,
               64'h01234567_89ABCDEF, 0, 0);
        do_mem(1, 3'b110, 64'h1004, 0, 64'h80000000_00000000, 5'd14, 1, 1,
               64'h00000000_80000000, 0, 0);
        do_mem(0, 3'b011, 64'h8000, 64'hDEADBEEF_CAFEF00D, 0, 5'd15, 0, 1, 0,
               64'hDEADBEEF_CAFEF00D, 8'hFF);

        do_illegal(0, 1, 3'b100, 64'h9000);
        do_illegal(1, 0, 3'b111, 64'h9000);
        do_illegal(1, 1, 3'b010, 64'h9000);
        do_illegal(0, 1, 3'b010, 64'h6002);
        do_illegal(1, 0, 3'b011, 64'h5004);

        // Ack while idle: no request, no write-back
        dmem_ack = 1;
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("idle_ack_req", {63'd0, dmem_req}, 64'd0);
        do_alu(64'hCAFE, 5'd31);

        repeat (3) @(posedge clk);
        #1;
        chk("wbq_drained", 64'(wbq.size()), 64'd0);
        chk("reqq_drained", 64'(reqq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 The block SHALL take EX/MEM inputs (all in): adder_out 64, branch target; zero 1, ALU zero; alu_result 64, address or result; write_data 64, store data; rd 5, destination register; funct3 3, access size/sign; branch, memread, memwrite, memtoreg, regwrite 1 each, control.
REQ-003 The block SHALL drive the data-memory port: dmem_req out 1; dmem_we out 1; dmem_addr out 64, doubleword-aligned (bits [2:0]=0); dmem_wdata out 64; dmem_wstrb out 8; dmem_ack in 1; dmem_rdata in 64.
REQ-004 The block SHALL drive control outputs: stall out 1, hold upstream stages; pcsrc out 1, take branch; branch_target out 64; mem_exc out 1, misaligned or illegal access.
REQ-005 The block SHALL drive MEM/WB outputs (registered): wb_read_data 64; wb_alu_result 64; wb_rd 5; wb_memtoreg 1; wb_regwrite 1.

Function
REQ-006 pcsrc SHALL equal branch & zero, combinationally.
REQ-007 branch_target SHALL equal adder_out, combinationally.
REQ-008 The FSM SHALL have two states: IDLE and BUSY.
REQ-009 An access is a cycle in IDLE with memread|memwrite=1; memread and memwrite both 1 SHALL be treated as illegal.
REQ-010 An access SHALL be legal when funct3 is a valid size for its kind and the address is size-aligned.
REQ-011 Valid sizes: loads 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores 000–011 only.
REQ-012 Alignment: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
REQ-013 A legal access SHALL move IDLE->BUSY and register dmem_addr, dmem_we, dmem_wdata, dmem_wstrb, lane offset, funct3, rd and control.
REQ-014 In BUSY, dmem_req SHALL be 1 and all request fields SHALL be held stable until dmem_ack.
REQ-015 On dmem_ack in BUSY, the block SHALL return to IDLE and load MEM/WB from the registered operation.
REQ-016 Store byte lanes SHALL be addressed by addr[2:0]: dmem_wstrb = size mask shifted left by addr[2:0]; dmem_wdata = write_data shifted left by 8*addr[2:0].
REQ-017 Load data SHALL be dmem_rdata shifted right by 8*offset, truncated to the access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU); LD passes through.
REQ-018 stall SHALL be 1 when (IDLE and legal access) or (BUSY and !dmem_ack); otherwise 0.
REQ-019 Memory-op latency SHALL be 2 cycles minimum (accept edge, ack edge), plus one cycle per ack wait.
REQ-020 A non-memory op SHALL load MEM/WB on the next edge, with wb_read_data=0.
REQ-021 On an illegal access: no request is issued; mem_exc pulses 1 for one cycle (registered); MEM/WB loads a bubble (wb_regwrite=0, wb_memtoreg=0); stall=0.
REQ-022 While stall=1, MEM/WB SHALL load a bubble each edge, except the ack edge.
REQ-023 A store SHALL complete with wb_regwrite=0 regardless of the regwrite input.
REQ-024 dmem_ack in IDLE SHALL be ignored.

Reset
REQ-025 On reset: state=IDLE; dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata = 0; all wb_* = 0; mem_exc=0.
REQ-026 Reset in BUSY SHALL abort the access: dmem_req=0 after the reset edge, and a subsequent ack is ignored.

Structure
REQ-027 Package riscv_mem_pkg SHALL hold the state enum, the funct3 size/sign constants and the size-to-strobe mask table.
REQ-028 Sub-module load_formatter (combinational: rdata, offset, funct3 -> extended data) SHALL be instantiated once.

Verification
REQ-029 LW at alu_result=0x1004 with dmem_rdata=0x80000000_00000000 and ack one cycle after req: expect dmem_addr=0x1000, wb_read_data=0xFFFFFFFF_80000000, stall high for 2 cycles.
REQ-030 SB write_data=0xAB at addr 0x2003 with ack delayed 3 cycles: expect dmem_wstrb=0x08, dmem_wdata[31:24]=0xAB, request fields stable, wb_regwrite=0.
REQ-031 LH at addr 0x3001: expect no dmem_req, mem_exc pulse, bubble, stall=0.
REQ-032 branch=1, zero=1, adder_out=0x400: expect pcsrc=1 and branch_target=0x400 in the same cycle; with zero=0, pcsrc=0.
REQ-033 Reset asserted in BUSY, then ack arrives 2 cycles later: expect state IDLE, dmem_req=0, no MEM/WB update from the ack.
REQ-034 LBU at addr 0x7 with rdata byte7=0xF0: expect wb_read_data=0xF0.
